counter_write_arbiter: RTL and testbench

//  Round-robin write arbiter in front of the 8-bit two-port shared counter.
//  Two requesters present req/data and get a one-cycle ack when their write is issued.
//  The arbiter drives at most one of the counter's wr1/wr2 in any cycle, so bitwise-OR

---
 rtl/counter_arb_pkg.sv | 18 +
 rtl/counter_write_arbiter_rr_pick2.sv | 30 +++
 rtl/counter_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_counter_write_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter write arbiter: state codes, requester ids, default width.
// Pure declarations; no logic or latency of its own.
// State codes are plain localparams so the FSM encoding stays legacy-compatible.
package counter_arb_pkg;

  localparam int DEF_WIDTH = 8;

  // FSM state codes
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT1 = 2'd1;
  localparam logic [1:0] GNT2 = 2'd2;

  // Requester ids; ID_NONE doubles as "no owner" and "no grant"
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] REQ1    = 2'd1;
  localparam logic [1:0] REQ2    = 2'd2;

endpackage

// File: rtl/counter_write_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick with an optional owner restriction.
// Zero latency: grant follows req/last/owner in the same cycle.
// No backpressure; an owner restricts the grant to itself while the other requester waits.
module rr_pick2
  import counter_arb_pkg::*;
(
  input  logic       req1,
  input  logic       req2,
  input  logic [1:0] last,
  input  logic [1:0] owner,
  output logic [1:0] grant
);

  // Owner (if any) is the only candidate; otherwise a tie goes to whoever was not served last
  always_comb begin
    grant = ID_NONE;
    if (owner == REQ1) begin
      if (req1) grant = REQ1;
    end else if (owner == REQ2) begin
      if (req2) grant = REQ2;
    end else if (req1 && req2) begin
      grant = (last == REQ1) ? REQ2 : REQ1;
    end else if (req1) begin
      grant = REQ1;
    end else if (req2) begin
      grant = REQ2;
    end
  end

endmodule

// File: rtl/counter_write_arbiter.sv
// Round-robin write arbiter in front of the two-port shared counter; optional lock via ARB_LOCK_EN.
// Latency: request sampled at edge N -> cnt_wr/ack asserted for exactly the cycle after edge N.
// Backpressure: requesters hold req/data until ack; at most one write per 2 cycles, never both ports.
module counter_write_arbiter
  import counter_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH
`ifdef ARB_LOCK_EN
  ,
  parameter int MAX_HOLD = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic [WIDTH-1:0] wrdata1,
  output logic             ack1,
  input  logic             req2,
  input  logic [WIDTH-1:0] wrdata2,
  output logic             ack2,
`ifdef ARB_LOCK_EN
  input  logic             lock1,
  input  logic             lock2,
`endif
  output logic             cnt_wr1,
  output logic [WIDTH-1:0] cnt_wrdata1,
  output logic             cnt_wr2,
  output logic [WIDTH-1:0] cnt_wrdata2,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [1:0]       pick;
  logic [1:0]       owner_mask;

`ifdef ARB_LOCK_EN
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  // Grants counted before this one; at HOLD_LAST the next locked grant is the final one
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [1:0]    owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;

  assign owner_mask = owner_q;
`else
  assign owner_mask = ID_NONE;
`endif

  rr_pick2 u_pick (
    .req1  (req1),
    .req2  (req2),
    .last  (last_q),
    .owner (owner_mask),
    .grant (pick)
  );

  // Next-state: IDLE picks a winner and captures its data, a grant lasts one cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data1_d = data1_q;
    data2_d = data2_q;
`ifdef ARB_LOCK_EN
    owner_d = owner_q;
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick == REQ1) begin
          state_d = GNT1;
          data1_d = wrdata1;
        end else if (pick == REQ2) begin
          state_d = GNT2;
          data2_d = wrdata2;
        end
`ifdef ARB_LOCK_EN
        // An owner that no longer requests nor locks gives up arbitration
        if ((owner_q == REQ1 && !req1 && !lock1) ||
            (owner_q == REQ2 && !req2 && !lock2)) begin
          owner_d = ID_NONE;
          hold_d  = '0;
        end
`endif
      end
      GNT1: begin
        state_d = IDLE;
        last_d  = REQ1;
`ifdef ARB_LOCK_EN
        if (lock1 && hold_q < HOLD_LAST) begin
          owner_d = REQ1;
          hold_d  = hold_q + 1'b1;
          last_d  = last_q;
        end else begin
          owner_d = ID_NONE;
          hold_d  = '0;
        end
`endif
      end
      GNT2: begin
        state_d = IDLE;
        last_d  = REQ2;
`ifdef ARB_LOCK_EN
        if (lock2 && hold_q < HOLD_LAST) begin
          owner_d = REQ2;
          hold_d  = hold_q + 1'b1;
          last_d  = last_q;
        end else begin
          owner_d = ID_NONE;
          hold_d  = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last resets to REQ2 so requester 1 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ2;
      data1_q <= '0;
      data2_q <= '0;
`ifdef ARB_LOCK_EN
      owner_q <= ID_NONE;
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
`ifdef ARB_LOCK_EN
      owner_q <= owner_d;
      hold_q  <= hold_d;
`endif
    end
  end

  // Outputs decode the state only, so reset clears them immediately
  assign cnt_wr1     = (state_q == GNT1);
  assign cnt_wr2     = (state_q == GNT2);
  assign ack1        = cnt_wr1;
  assign ack2        = cnt_wr2;
  assign cnt_wrdata1 = cnt_wr1 ? data1_q : '0;
  assign cnt_wrdata2 = cnt_wr2 ? data2_q : '0;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_counter_write_arbiter.sv
// Bench for counter_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_counter_write_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req1 = 1'b0, req2 = 1'b0;
  logic [W-1:0] wrdata1 = '0, wrdata2 = '0;
  logic         ack1, ack2, cnt_wr1, cnt_wr2, busy;
  logic [W-1:0] cnt_wrdata1, cnt_wrdata2;
`ifdef ARB_LOCK_EN
  logic         lock1 = 1'b0, lock2 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: who is showing a write this cycle, with what data, and fairness history
  int           m_busy = 0;
  int           m_who  = 0;
  int           m_last = 2;
  int           m_w    = 0;
  int           m_owner = 0;
  int           m_hold  = 0;
  logic [W-1:0] m_data = '0;
  bit           m_lk;

  counter_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req1        (req1),
    .wrdata1     (wrdata1),
    .ack1        (ack1),
    .req2        (req2),
    .wrdata2     (wrdata2),
    .ack2        (ack2),
`ifdef ARB_LOCK_EN
    .lock1       (lock1),
    .lock2       (lock2),
`endif
    .cnt_wr1     (cnt_wr1),
    .cnt_wrdata1 (cnt_wrdata1),
    .cnt_wr2     (cnt_wr2),
    .cnt_wrdata2 (cnt_wrdata2),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge, then compare all outputs just after it
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_who = 0; m_last = 2; m_owner = 0; m_hold = 0;
    end else if (m_busy != 0) begin
`ifdef ARB_LOCK_EN
      m_lk = (m_who == 1) ? lock1 : lock2;
      if (m_lk && (m_hold + 1) < MH) begin
        m_owner = m_who;
        m_hold  = m_hold + 1;
      end else begin
        m_owner = 0;
        m_hold  = 0;
        m_last  = m_who;
      end
`else
      m_last = m_who;
`endif
      m_busy = 0;
    end else begin
      m_w = 0;
      if (m_owner != 0) begin
        m_lk = 1'b0;
`ifdef ARB_LOCK_EN
        m_lk = (m_owner == 1) ? lock1 : lock2;
`endif
        if ((m_owner == 1) ? req1 : req2) m_w = m_owner;
        else if (!m_lk) begin
          m_owner = 0;
          m_hold  = 0;
        end
      end else if (req1 && req2) m_w = 3 - m_last;
      else if (req1) m_w = 1;
      else if (req2) m_w = 2;
      if (m_w != 0) begin
        m_busy = 1;
        m_who  = m_w;
        m_data = (m_w == 1) ? wrdata1 : wrdata2;
      end
    end
    #1;
    check("cnt_wr1", cnt_wr1, (m_busy != 0 && m_who == 1));
    check("cnt_wr2", cnt_wr2, (m_busy != 0 && m_who == 2));
    check("ack1", ack1, (m_busy != 0 && m_who == 1));
    check("ack2", ack2, (m_busy != 0 && m_who == 2));
    check("cnt_wrdata1", cnt_wrdata1, (m_busy != 0 && m_who == 1) ? m_data : 8'h00);
    check("cnt_wrdata2", cnt_wrdata2, (m_busy != 0 && m_who == 2) ? m_data : 8'h00);
    check("busy", busy, (m_busy != 0));
    check("wr_mutex", cnt_wr1 & cnt_wr2, 0);
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef ARB_LOCK_EN
  // Record the owner of the first n acks, dropping lock1 after drop_after acks (0 = never)
  task automatic ack_seq(input int n, input int drop_after, output int seq[8]);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) seq[i] = 0;
    for (int c = 0; c < 60 && k < n; c++) begin
      @(posedge clk); #2;
      if (ack1) begin seq[k] = 1; k++; end
      else if (ack2) begin seq[k] = 2; k++; end
      if (drop_after != 0 && k == drop_after) lock1 = 1'b0;
    end
    check("lock_ack_count", k, n);
  endtask
`endif

  initial begin
    logic [W-1:0] seq_exp [8];
    logic [W-1:0] got;
    int n1, n2;
`ifdef ARB_LOCK_EN
    int aseq [8];
`endif
    seq_exp = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write from requester 1
    @(negedge clk); req1 = 1'b1; wrdata1 = 8'h3C;
    @(posedge clk); #2;
    check("t1_wr1", cnt_wr1, 1);
    check("t1_data1", cnt_wrdata1, 8'h3C);
    check("t1_ack1", ack1, 1);
    check("t1_wr2", cnt_wr2, 0);
    @(negedge clk); req1 = 1'b0;
    @(negedge clk);

    // Both requesting from reset: strict alternation starting with requester 1
    do_reset();
    req1 = 1'b1; req2 = 1'b1; wrdata1 = 8'h11; wrdata2 = 8'h22;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      got = (cnt_wr1 ? cnt_wrdata1 : 8'h00) | (cnt_wr2 ? cnt_wrdata2 : 8'h00);
      check($sformatf("t2_seq%0d", i), got, seq_exp[i]);
    end
    @(negedge clk); req1 = 1'b0; req2 = 1'b0;

    // Requester 2 alone for 4 cycles: two acks, then 2 is "last" so 1 wins a tie
    @(negedge clk); req2 = 1'b1; wrdata2 = 8'h5A;
    n1 = 0; n2 = 0;
    repeat (4) begin
      @(posedge clk); #2;
      n1 += int'(ack1); n2 += int'(ack2);
    end
    @(negedge clk); req2 = 1'b0;
    check("t3_ack2_cnt", n2, 2);
    check("t3_ack1_cnt", n1, 0);
    @(negedge clk); req1 = 1'b1; req2 = 1'b1;
    @(posedge clk); #2;
    check("t3_tie_ack1", ack1, 1);
    @(negedge clk); req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);

    // Reset during GNT1 drops the write at once; afterwards 1 wins the tie again
    req1 = 1'b1; wrdata1 = 8'hA5;
    @(posedge clk); #2;
    check("t4_pre_wr1", cnt_wr1, 1);
    #1 rst = 1'b1; req1 = 1'b0;
    #1;
    check("t4_rst_wr1", cnt_wr1, 0);
    check("t4_rst_ack1", ack1, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    req1 = 1'b1; req2 = 1'b1;
    @(posedge clk); #2;
    check("t4_first_ack1", ack1, 1);
    check("t4_first_ack2", ack2, 0);
    @(negedge clk); req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);

    // Requester 1 pulsed only during a GNT2 cycle is never served
    req2 = 1'b1; wrdata2 = 8'h77;
    @(posedge clk); #3; req1 = 1'b1; req2 = 1'b0; wrdata1 = 8'hEE;
    @(posedge clk); #3; req1 = 1'b0;
    n1 = 0;
    repeat (3) begin
      @(posedge clk); #2;
      n1 += int'(ack1) + int'(cnt_wr1);
    end
    check("t6_no_ack1", n1, 0);

`ifdef ARB_LOCK_EN
    // Lock held: MAX_HOLD grants to 1, then forced release lets 2 in
    do_reset();
    lock1 = 1'b1; req1 = 1'b1; req2 = 1'b1; wrdata1 = 8'h31; wrdata2 = 8'h32;
    ack_seq(5, 0, aseq);
    for (int i = 0; i < 5; i++) check($sformatf("t5_hold%0d", i), aseq[i], (i < 4) ? 1 : 2);
    @(negedge clk); lock1 = 1'b0; req1 = 1'b0; req2 = 1'b0;

    // Lock dropped at the 2nd grant: requester 2 follows immediately
    do_reset();
    lock1 = 1'b1; req1 = 1'b1; req2 = 1'b1;
    ack_seq(3, 2, aseq);
    check("t5_rel0", aseq[0], 1);
    check("t5_rel1", aseq[1], 1);
    check("t5_rel2", aseq[2], 2);
    @(negedge clk); lock1 = 1'b0; req1 = 1'b0; req2 = 1'b0;
`endif

    // Randomized traffic, checked every cycle by the model
    do_reset();
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) req1 = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) != 0) req2 = $urandom_range(0, 2) != 0;
      wrdata1 = W'($urandom);
      wrdata2 = W'($urandom);
`ifdef ARB_LOCK_EN
      lock1 = $urandom_range(0, 4) == 0;
      lock2 = $urandom_range(0, 4) == 0;
`endif
    end
    @(negedge clk); req1 = 1'b0; req2 = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
